// File: rtl/otter_intr_ctrl.sv
// otter_intr_ctrl -- interrupt front end for the OTTER CPU, sitting directly
// upstream of the CSR block.
//
// Each external line is synchronised, then edge-detected. A rising edge sets
// a per-source pending bit. At an instruction boundary with the global enable
// set, the lowest-index pending source is picked. A one-cycle INT_TAKEN pulse
// then redirects the PC to the handler vector. Handler occupancy is tracked
// until MRET.
//
// Ports
//   CLK         system clock
//   RST         synchronous active-high reset
//   INTR        async external interrupt lines (rising edge = request)
//   CSR_MIE     global interrupt enable from the CSR block
//   CSR_MTVEC   handler vector from the CSR block
//   INSTR_DONE  current instruction retires this cycle
//   MRET        mret executing (1-cycle pulse)
//   INT_TAKEN   1-cycle pulse to CSR and control FSM
//   PC_SEL_INT  PC mux select for INT_VECTOR (same as INT_TAKEN)
//   INT_VECTOR  handler target address (pass-through of CSR_MTVEC)
//   INT_CAUSE   index of the source being / last serviced
//   INT_PENDING per-source pending bits
//   IN_HANDLER  high from the INT_TAKEN cycle until MRET is accepted
module otter_intr_ctrl #(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] INTR,
  input  logic               CSR_MIE,
  input  logic [31:0]        CSR_MTVEC,
  input  logic               INSTR_DONE,
  input  logic               MRET,
  output logic               INT_TAKEN,
  output logic               PC_SEL_INT,
  output logic [31:0]        INT_VECTOR,
  output logic [3:0]         INT_CAUSE,
  output logic [NUM_SRC-1:0] INT_PENDING,
  output logic               IN_HANDLER
);

  typedef enum logic [1:0] {ST_RUN, ST_TAKE, ST_HANDLER} state_e;

  state_e                                state_q, state_d;
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0]   sync_q, sync_d;
  logic [NUM_SRC-1:0]                    edge_q;
  logic [NUM_SRC-1:0]                    pend_q, pend_d;
  logic [3:0]                            cause_q, cause_d;
  logic [NUM_SRC-1:0]                    rise;
  logic [NUM_SRC-1:0]                    clr;
  logic [3:0]                            sel_idx;

  // Synchroniser shift: stage 0 samples the raw line.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = INTR;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

  // Fixed priority: the scan runs from high to low, so the lowest index wins.
  always_comb begin
    sel_idx = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (pend_q[i-1]) sel_idx = 4'(i - 1);
    end
  end

  // Clear the serviced bit during TAKE. The rise term is ORed in afterwards,
  // so a new edge on the same source in that cycle is kept.
  always_comb begin
    clr = '0;
    if (state_q == ST_TAKE) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        clr[i] = (cause_q == 4'(i));
      end
    end
    pend_d = (pend_q & ~clr) | rise;
  end

  // Next-state logic; the cause is latched on the RUN->TAKE decision.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      ST_RUN: begin
        if (INSTR_DONE && CSR_MIE && (|pend_q)) begin
          state_d = ST_TAKE;
          cause_d = sel_idx;
        end
      end
      ST_TAKE:    state_d = ST_HANDLER;
      ST_HANDLER: if (MRET) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
      sync_q  <= '0;
      edge_q  <= '0;
      pend_q  <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      edge_q  <= sync_q[SYNC_STAGES-1];
      pend_q  <= pend_d;
      cause_q <= cause_d;
    end
  end

  // Outputs are a decode of the registered state.
  always_comb begin
    INT_TAKEN  = (state_q == ST_TAKE);
    PC_SEL_INT = (state_q == ST_TAKE);
    IN_HANDLER = (state_q != ST_RUN);
  end

  assign INT_VECTOR  = CSR_MTVEC;
  assign INT_CAUSE   = cause_q;
  assign INT_PENDING = pend_q;

endmodule

// File: tb/tb_otter_intr_ctrl.sv
module tb_otter_intr_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned S = 2;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [N-1:0] INTR = '0;
  logic         CSR_MIE = 1'b0;
  logic [31:0]  CSR_MTVEC = 32'h100;
  logic         INSTR_DONE = 1'b0;
  logic         MRET = 1'b0;
  logic         INT_TAKEN, PC_SEL_INT, IN_HANDLER;
  logic [31:0]  INT_VECTOR;
  logic [3:0]   INT_CAUSE;
  logic [N-1:0] INT_PENDING;

  int vectors = 0;
  int miscompares = 0;

  otter_intr_ctrl #(.NUM_SRC(N), .SYNC_STAGES(S)) dut (
    .CLK(CLK), .RST(RST), .INTR(INTR), .CSR_MIE(CSR_MIE), .CSR_MTVEC(CSR_MTVEC),
    .INSTR_DONE(INSTR_DONE), .MRET(MRET), .INT_TAKEN(INT_TAKEN),
    .PC_SEL_INT(PC_SEL_INT), .INT_VECTOR(INT_VECTOR), .INT_CAUSE(INT_CAUSE),
    .INT_PENDING(INT_PENDING), .IN_HANDLER(IN_HANDLER)
  );

  always #5 CLK = ~CLK;

  // Reference model: line history, pending set, and two flags describing
  // where the core is in interrupt service.
  logic [N-1:0] m_hist [0:S+1];
  logic [N-1:0] m_pend;
  bit           m_taking;
  bit           m_in_isr;
  logic [3:0]   m_cause;

  function automatic logic [3:0] lowest_set(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  function automatic void model_edge();
    logic [N-1:0] old_pend, rise;
    if (RST) begin
      for (int j = 0; j <= S + 1; j++) m_hist[j] = '0;
      m_pend = '0; m_taking = 0; m_in_isr = 0; m_cause = '0;
      return;
    end
    for (int j = S + 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = INTR;
    rise = m_hist[S] & ~m_hist[S+1];
    old_pend = m_pend;
    m_pend = old_pend;
    if (m_taking) m_pend[m_cause] = 1'b0;
    m_pend = m_pend | rise;
    if (m_taking) begin
      m_taking = 0; m_in_isr = 1;
    end else if (m_in_isr) begin
      if (MRET) m_in_isr = 0;
    end else if (INSTR_DONE && CSR_MIE && old_pend != '0) begin
      m_taking = 1; m_cause = lowest_set(old_pend);
    end
  endfunction

  // Advance one clock, update the model with the inputs sampled at that edge,
  // then settle 1 time unit before anyone looks at outputs.
  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; INTR = '0; MRET = 1'b0; CSR_MIE = 1'b0; INSTR_DONE = 1'b0;
    tick(); tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({INT_TAKEN, PC_SEL_INT, IN_HANDLER} !== 3'b000) begin
      miscompares++; $display("FAIL reset_ctl: got %b expected 000", {INT_TAKEN, PC_SEL_INT, IN_HANDLER});
    end
    vectors++;
    if (INT_PENDING !== '0 || INT_CAUSE !== 4'd0) begin
      miscompares++; $display("FAIL reset_state: pend=%h cause=%h expected 0/0", INT_PENDING, INT_CAUSE);
    end
    CSR_MTVEC = 32'hDEAD_BEE0; #1;
    vectors++;
    if (INT_VECTOR !== 32'hDEAD_BEE0) begin
      miscompares++; $display("FAIL vector_pass: got %h expected deadbee0", INT_VECTOR);
    end
  endtask

  task automatic test_single();
    do_reset();
    CSR_MIE = 1'b1; CSR_MTVEC = 32'h100; INSTR_DONE = 1'b1;
    INTR = 4'b0001;
    tick(); tick();
    vectors++;
    if (INT_PENDING[0] !== 1'b0) begin
      miscompares++; $display("FAIL single_early: pend0=%b expected 0 at cycle 2", INT_PENDING[0]);
    end
    tick();
    vectors++;
    if (INT_PENDING[0] !== 1'b1 || INT_TAKEN !== 1'b0) begin
      miscompares++; $display("FAIL single_pend: pend0=%b taken=%b expected 1/0 at cycle 3", INT_PENDING[0], INT_TAKEN);
    end
    tick();
    vectors++;
    if (INT_TAKEN !== 1'b1 || PC_SEL_INT !== 1'b1 || INT_VECTOR !== 32'h100 || INT_CAUSE !== 4'd0) begin
      miscompares++;
      $display("FAIL single_take: taken=%b pcsel=%b vec=%h cause=%h expected 1/1/100/0", INT_TAKEN, PC_SEL_INT, INT_VECTOR, INT_CAUSE);
    end
    tick();
    vectors++;
    if (INT_PENDING[0] !== 1'b0 || INT_TAKEN !== 1'b0 || IN_HANDLER !== 1'b1) begin
      miscompares++; $display("FAIL single_after: pend0=%b taken=%b inh=%b expected 0/0/1", INT_PENDING[0], INT_TAKEN, IN_HANDLER);
    end
    INTR = '0; MRET = 1'b1; tick(); MRET = 1'b0; tick();
    vectors++;
    if (IN_HANDLER !== 1'b0) begin
      miscompares++; $display("FAIL single_mret: in_handler=%b expected 0", IN_HANDLER);
    end
  endtask

  task automatic test_priority();
    bit seen;
    do_reset();
    CSR_MIE = 1'b1; INSTR_DONE = 1'b1; INTR = 4'b0110;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = INT_TAKEN; end
    vectors++;
    if (!seen || INT_CAUSE !== 4'd1) begin
      miscompares++; $display("FAIL prio_first: seen=%0d cause=%h expected 1/1", seen, INT_CAUSE);
    end
    CSR_MIE = 1'b0;
    tick(); tick();
    MRET = 1'b1; tick(); MRET = 1'b0;
    tick(); tick();
    vectors++;
    if (INT_TAKEN !== 1'b0 || INT_PENDING !== 4'b0100) begin
      miscompares++; $display("FAIL prio_masked: taken=%b pend=%h expected 0/4", INT_TAKEN, INT_PENDING);
    end
    CSR_MIE = 1'b1; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin tick(); seen = INT_TAKEN; end
    vectors++;
    if (!seen || INT_CAUSE !== 4'd2) begin
      miscompares++; $display("FAIL prio_second: seen=%0d cause=%h expected 1/2", seen, INT_CAUSE);
    end
    tick(); INTR = '0; MRET = 1'b1; tick(); MRET = 1'b0;
  endtask

  // Leaves the DUT in its TAKE cycle for cause 3.
  task automatic test_masked();
    int takes;
    do_reset();
    CSR_MIE = 1'b0; INSTR_DONE = 1'b1;
    INTR = 4'b1000; tick(); INTR = '0;
    takes = 0;
    for (int i = 0; i < 50; i++) begin tick(); if (INT_TAKEN) takes++; end
    vectors++;
    if (takes != 0 || INT_PENDING[3] !== 1'b1) begin
      miscompares++; $display("FAIL masked_hold: takes=%0d pend3=%b expected 0/1", takes, INT_PENDING[3]);
    end
    CSR_MIE = 1'b1; tick();
    vectors++;
    if (INT_TAKEN !== 1'b1 || INT_CAUSE !== 4'd3) begin
      miscompares++; $display("FAIL masked_take: taken=%b cause=%h expected 1/3", INT_TAKEN, INT_CAUSE);
    end
  endtask

  task automatic test_no_nesting();
    int takes;
    tick();
    CSR_MIE = 1'b1; INTR = 4'b0001; takes = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (INT_TAKEN) takes++; end
    vectors++;
    if (takes != 0 || INT_PENDING[0] !== 1'b1 || IN_HANDLER !== 1'b1) begin
      miscompares++; $display("FAIL nest_block: takes=%0d pend0=%b inh=%b expected 0/1/1", takes, INT_PENDING[0], IN_HANDLER);
    end
    MRET = 1'b1; tick(); MRET = 1'b0; tick();
    vectors++;
    if (INT_TAKEN !== 1'b1 || INT_CAUSE !== 4'd0) begin
      miscompares++; $display("FAIL nest_after: taken=%b cause=%h expected 1/0", INT_TAKEN, INT_CAUSE);
    end
    tick(); INTR = '0; MRET = 1'b1; tick(); MRET = 1'b0;
  endtask

  task automatic test_held_line();
    int takes;
    do_reset();
    CSR_MIE = 1'b1; INSTR_DONE = 1'b0; INTR = 4'b0001; takes = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (INT_TAKEN) takes++; end
    vectors++;
    if (takes != 0 || INT_PENDING[0] !== 1'b1) begin
      miscompares++; $display("FAIL held_wait: takes=%0d pend0=%b expected 0/1", takes, INT_PENDING[0]);
    end
    INSTR_DONE = 1'b1;
    for (int i = 0; i < 40; i++) begin
      MRET = (i == 3);
      tick();
      if (INT_TAKEN) takes++;
    end
    MRET = 1'b0;
    vectors++;
    if (takes != 1 || INT_PENDING !== '0 || IN_HANDLER !== 1'b0) begin
      miscompares++; $display("FAIL held_once: takes=%0d pend=%h inh=%b expected 1/0/0", takes, INT_PENDING, IN_HANDLER);
    end
    INTR = '0;
  endtask

  task automatic test_reset_mid_handler();
    bit seen;
    int takes;
    do_reset();
    CSR_MIE = 1'b1; INSTR_DONE = 1'b1; INTR = 4'b0001; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin tick(); seen = INT_TAKEN; end
    INTR = 4'b0011;
    for (int i = 0; i < 5; i++) tick();
    vectors++;
    if (!seen || IN_HANDLER !== 1'b1 || INT_PENDING[1] !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_setup: seen=%0d inh=%b pend1=%b expected 1/1/1", seen, IN_HANDLER, INT_PENDING[1]);
    end
    RST = 1'b1; INTR = '0; tick(); RST = 1'b0;
    vectors++;
    if (IN_HANDLER !== 1'b0 || INT_PENDING !== '0 || INT_CAUSE !== 4'd0 || INT_TAKEN !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_clear: inh=%b pend=%h cause=%h taken=%b expected 0/0/0/0", IN_HANDLER, INT_PENDING, INT_CAUSE, INT_TAKEN);
    end
    takes = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (INT_TAKEN) takes++; end
    vectors++;
    if (takes != 0) begin
      miscompares++; $display("FAIL rstmid_quiet: takes=%0d expected 0", takes);
    end
  endtask

  task automatic test_random();
    bit prev_taken;
    do_reset();
    prev_taken = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) INTR[i] = ~INTR[i];
      CSR_MIE    = ($urandom_range(0, 3) != 0);
      INSTR_DONE = ($urandom_range(0, 2) != 0);
      MRET       = ($urandom_range(0, 9) == 0);
      RST        = ($urandom_range(0, 199) == 0);
      CSR_MTVEC  = $urandom;
      tick();
      vectors++;
      if (INT_TAKEN !== m_taking || PC_SEL_INT !== m_taking) begin
        miscompares++; $display("FAIL rnd_taken c=%0d: got %b/%b expected %b", c, INT_TAKEN, PC_SEL_INT, m_taking);
      end
      vectors++;
      if (IN_HANDLER !== (m_taking | m_in_isr)) begin
        miscompares++; $display("FAIL rnd_inh c=%0d: got %b expected %b", c, IN_HANDLER, m_taking | m_in_isr);
      end
      vectors++;
      if (INT_PENDING !== m_pend || INT_CAUSE !== m_cause) begin
        miscompares++; $display("FAIL rnd_state c=%0d: pend=%h cause=%h expected %h/%h", c, INT_PENDING, INT_CAUSE, m_pend, m_cause);
      end
      vectors++;
      if (INT_VECTOR !== CSR_MTVEC) begin
        miscompares++; $display("FAIL rnd_vec c=%0d: got %h expected %h", c, INT_VECTOR, CSR_MTVEC);
      end
      vectors++;
      if (prev_taken && INT_TAKEN) begin
        miscompares++; $display("FAIL rnd_b2b c=%0d: taken %b after taken, expected 0", c, INT_TAKEN);
      end
      prev_taken = INT_TAKEN;
    end
    RST = 1'b0; MRET = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_masked();
    test_no_nesting();
    test_held_line();
    test_reset_mid_handler();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
